// File: rtl/pmod_link_scheduler.sv
// Time-shares the 3-wire PMOD link between the state and location requesters,
// serializing one tagged frame at a time followed by a fixed idle gap.
module pmod_link_scheduler #(
    parameter int STATE_W        = 16,
    parameter int LOC_W          = 16,
    parameter int CLK_DIV        = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int LOC_STARVE_MAX = 4
) (
    input  logic               clk_pixel_in,
    input  logic               rst_in,
    input  logic               state_req_in,
    input  logic [STATE_W-1:0] state_data_in,
    output logic               state_ack_out,
    input  logic               loc_req_in,
    input  logic [LOC_W-1:0]   loc_data_in,
    output logic               loc_ack_out,
    output logic               data_out,
    output logic               data_clk_out,
    output logic               sel_out,
    output logic               busy_out
);

    localparam int MAX_W   = (STATE_W > LOC_W) ? STATE_W : LOC_W;
    localparam int FRAME_W = MAX_W + 1;
    localparam int BIT_CW  = $clog2(FRAME_W) + 1;
    localparam int DIV_CW  = $clog2(CLK_DIV) + 1;
    localparam int GAP_CW  = $clog2(GAP_CYCLES) + 1;
    localparam int STV_CW  = $clog2(LOC_STARVE_MAX + 1);
    localparam int ST_SH   = FRAME_W - 1 - STATE_W;
    localparam int LOC_SH  = FRAME_W - 1 - LOC_W;

    localparam logic [BIT_CW-1:0] ST_LAST  = BIT_CW'(STATE_W);
    localparam logic [BIT_CW-1:0] LOC_LAST = BIT_CW'(LOC_W);
    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(CLK_DIV - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_CYCLES - 1);
    localparam logic [STV_CW-1:0] STV_MAX  = STV_CW'(LOC_STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [BIT_CW-1:0]   bit_q, bit_d;
    logic [BIT_CW-1:0]   last_q, last_d;
    logic [DIV_CW-1:0]   div_q, div_d;
    logic [GAP_CW-1:0]   gap_q, gap_d;
    logic [STV_CW-1:0]   starve_q, starve_d;
    logic                state_ack_q, state_ack_d;
    logic                loc_ack_q, loc_ack_d;
    logic                sel_q, sel_d;
    logic                dclk_q, dclk_d;
    logic                data_q, data_d;
    logic                busy_q, busy_d;
    logic                grant_loc;
    logic [FRAME_W-1:0]  st_frame;
    logic [FRAME_W-1:0]  loc_frame;

    // Frames are left-aligned so the tag always sits in the MSB regardless of payload width.
    assign st_frame  = FRAME_W'({1'b1, state_data_in}) << ST_SH;
    assign loc_frame = FRAME_W'({1'b0, loc_data_in}) << LOC_SH;

    always_comb begin
        fsm_d       = fsm_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        last_d      = last_q;
        div_d       = div_q;
        gap_d       = gap_q;
        starve_d    = starve_q;
        state_ack_d = 1'b0;
        loc_ack_d   = 1'b0;
        sel_d       = sel_q;
        dclk_d      = dclk_q;
        data_d      = data_q;
        busy_d      = busy_q;
        grant_loc   = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (state_req_in || loc_req_in) begin
                    // State normally wins a tie; a saturated starve count hands the tie to location.
                    grant_loc = loc_req_in && (!state_req_in || (starve_q == STV_MAX));
                    if (grant_loc) begin
                        loc_ack_d = 1'b1;
                        shift_d   = loc_frame;
                        last_d    = LOC_LAST;
                        data_d    = 1'b0;
                        starve_d  = '0;
                    end else begin
                        state_ack_d = 1'b1;
                        shift_d     = st_frame;
                        last_d      = ST_LAST;
                        data_d      = 1'b1;
                        if (loc_req_in && (starve_q != STV_MAX)) begin
                            starve_d = starve_q + STV_CW'(1);
                        end
                    end
                    sel_d  = 1'b1;
                    dclk_d = 1'b0;
                    bit_d  = '0;
                    div_d  = '0;
                    busy_d = 1'b1;
                    fsm_d  = SHIFT;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!dclk_q) begin
                        dclk_d = 1'b1;
                    end else if (bit_q == last_q) begin
                        sel_d  = 1'b0;
                        dclk_d = 1'b0;
                        data_d = 1'b0;
                        gap_d  = '0;
                        fsm_d  = GAP;
                    end else begin
                        // Next bit goes out on the same cycle the clock returns low.
                        bit_d   = bit_q + BIT_CW'(1);
                        dclk_d  = 1'b0;
                        shift_d = shift_q << 1;
                        data_d  = shift_q[FRAME_W-2];
                    end
                end else begin
                    div_d = div_q + DIV_CW'(1);
                end
            end

            GAP: begin
                if (gap_q == GAP_LAST) begin
                    busy_d = 1'b0;
                    fsm_d  = IDLE;
                end else begin
                    gap_d = gap_q + GAP_CW'(1);
                end
            end

            default: begin
                fsm_d  = IDLE;
                sel_d  = 1'b0;
                dclk_d = 1'b0;
                data_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            fsm_q       <= IDLE;
            shift_q     <= '0;
            bit_q       <= '0;
            last_q      <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            starve_q    <= '0;
            state_ack_q <= 1'b0;
            loc_ack_q   <= 1'b0;
            sel_q       <= 1'b0;
            dclk_q      <= 1'b0;
            data_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            last_q      <= last_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            starve_q    <= starve_d;
            state_ack_q <= state_ack_d;
            loc_ack_q   <= loc_ack_d;
            sel_q       <= sel_d;
            dclk_q      <= dclk_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign state_ack_out = state_ack_q;
    assign loc_ack_out   = loc_ack_q;
    assign data_out      = data_q;
    assign data_clk_out  = dclk_q;
    assign sel_out       = sel_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_pmod_link_scheduler.sv
// Bench for pmod_link_scheduler: a receiver-side monitor rebuilds frames from the wires and
// compares them with frames predicted from the arbitration rules.
module tb_pmod_link_scheduler;

   localparam int SW        = 8;
   localparam int LW        = 8;
   localparam int CD        = 2;
   localparam int GAP       = 4;
   localparam int SMAX      = 2;
   localparam int FRAME_CYC = (1 + SW) * 2 * CD;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       sReq  = 1'b0;
   logic       lReq  = 1'b0;
   logic [7:0] sData = 8'h00;
   logic [7:0] lData = 8'h00;
   logic       sAck, lAck, dOut, dClk, sel, busy;

   int vectors     = 0;
   int miscompares = 0;
   int modelStarve = 0;

   typedef struct {
      logic [8:0] bits;
      int         nbits;
      int         len;
      int         lowBefore;
   } frame_t;

   frame_t obsQ[$];
   frame_t expQ[$];

   always #5 clk = ~clk;

   pmod_link_scheduler #(
      .STATE_W(SW), .LOC_W(LW), .CLK_DIV(CD), .GAP_CYCLES(GAP), .LOC_STARVE_MAX(SMAX)
   ) dut (
      .clk_pixel_in (clk),
      .rst_in       (rst),
      .state_req_in (sReq),
      .state_data_in(sData),
      .state_ack_out(sAck),
      .loc_req_in   (lReq),
      .loc_data_in  (lData),
      .loc_ack_out  (lAck),
      .data_out     (dOut),
      .data_clk_out (dClk),
      .sel_out      (sel),
      .busy_out     (busy)
   );

   // Receiver model: samples just after each rising clock, rebuilds frames, tracks link invariants.
   logic       prevSel = 1'b0, prevClk = 1'b0, prevData = 1'b0, prevBusy = 1'b0;
   logic [8:0] curBits = '0;
   int         curN = 0, curLen = 0, lowCnt = -1, riseLow = -1;
   bit         inFrame = 1'b0;
   int         highChgCnt = 0, badAckCnt = 0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         inFrame  = 1'b0;
         lowCnt   = -1;
         prevSel  = 1'b0;
         prevClk  = 1'b0;
         prevData = 1'b0;
         prevBusy = 1'b0;
      end else begin
         if (dClk && prevClk && (dOut !== prevData)) highChgCnt++;
         if ((sAck || lAck) && !(sel && !prevSel && !prevBusy)) badAckCnt++;
         if (sel && !prevSel) begin
            inFrame = 1'b1;
            curBits = '0;
            curN    = 0;
            curLen  = 0;
            riseLow = lowCnt;
         end
         if (sel && inFrame) begin
            curLen++;
            if (dClk && !prevClk) begin
               curBits = {curBits[7:0], dOut};
               curN++;
            end
         end
         if (!sel && prevSel && inFrame) begin
            obsQ.push_back('{bits: curBits, nbits: curN, len: curLen, lowBefore: riseLow});
            inFrame = 1'b0;
            lowCnt  = 1;
         end else if (!sel && lowCnt >= 0) begin
            lowCnt++;
         end
         prevSel  = sel;
         prevClk  = dClk;
         prevData = dOut;
         prevBusy = busy;
      end
   end

   // Records one miscompare with its observed and expected values.
   task automatic reportFail(input string tag, input longint obs, input longint exp);
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Drives both request channels and their payloads together.
   task automatic applyStimulus(input logic s, input logic l, input logic [7:0] sd, input logic [7:0] ld);
      sData = sd;
      lData = ld;
      sReq  = s;
      lReq  = l;
   endtask

   // Waits for a grant, checks the winner against the arbitration rule and queues the expected frame.
   task automatic awaitGrant(output bit gotLoc);
      int waited = 0;
      bit expLoc;
      logic [1:0] expSel;
      while (!(sAck || lAck) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if ((sAck || lAck) !== 1'b1) reportFail("ack seen", (sAck || lAck), 1);
      gotLoc = lAck;
      if (sAck || lAck) begin
         expLoc = lReq && (!sReq || modelStarve >= SMAX);
         expSel = expLoc ? 2'b01 : 2'b10;
         vectors++;
         if ({sAck, lAck} !== expSel) reportFail("ack select", {sAck, lAck}, expSel);
         if (expLoc) begin
            modelStarve = 0;
            expQ.push_back('{bits: {1'b0, lData}, nbits: 1 + LW, len: FRAME_CYC, lowBefore: 0});
         end else begin
            if (lReq) modelStarve = (modelStarve + 1 > SMAX) ? SMAX : modelStarve + 1;
            expQ.push_back('{bits: {1'b1, sData}, nbits: 1 + SW, len: FRAME_CYC, lowBefore: 0});
         end
         @(negedge clk);
         vectors++;
         if ({sAck, lAck} !== 2'b00) reportFail("ack single pulse", {sAck, lAck}, 0);
      end
   endtask

   // Drains the monitor and compares every observed frame with its predicted counterpart.
   task automatic checkOutput(input string tag, input int exactGap);
      int waited = 0;
      int idx    = 0;
      frame_t e, o;
      bit gapOk;
      while ((obsQ.size() < expQ.size() || busy === 1'b1) && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (obsQ.size() !== expQ.size()) reportFail({tag, " frame count"}, obsQ.size(), expQ.size());
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         e = expQ.pop_front();
         o = obsQ.pop_front();
         vectors++;
         if (o.bits !== e.bits) reportFail({tag, " bits"}, o.bits, e.bits);
         vectors++;
         if (o.nbits !== e.nbits) reportFail({tag, " bit count"}, o.nbits, e.nbits);
         vectors++;
         if (o.len !== e.len) reportFail({tag, " sel length"}, o.len, e.len);
         if (exactGap >= 0 && idx > 0) begin
            vectors++;
            if (o.lowBefore !== exactGap) reportFail({tag, " inter-frame gap"}, o.lowBefore, exactGap);
         end else begin
            gapOk = (o.lowBefore < 0 || o.lowBefore >= GAP + 1);
            vectors++;
            if (gapOk !== 1'b1) reportFail({tag, " minimum gap"}, o.lowBefore, GAP + 1);
         end
         idx++;
      end
      obsQ.delete();
      expQ.delete();
   endtask

   // Main sequence: directed scenarios from the test plan followed by randomized traffic.
   initial begin
      bit         gl;
      logic [5:0] order;
      int         waited, cnt;

      repeat (3) @(negedge clk);
      vectors++;
      if ({sAck, lAck, dOut, dClk, sel, busy} !== 6'b0)
         reportFail("reset outputs", {sAck, lAck, dOut, dClk, sel, busy}, 0);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({sel, busy} !== 2'b00) reportFail("idle after reset", {sel, busy}, 0);

      $display("[TB] state frame A5");
      applyStimulus(1'b1, 1'b0, 8'hA5, 8'h00);
      awaitGrant(gl);
      sReq   = 1'b0;
      waited = 0;
      while (sel === 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (cnt !== GAP) reportFail("gap busy cycles", cnt, GAP);
      checkOutput("state A5", -1);

      $display("[TB] location frame 3C");
      applyStimulus(1'b0, 1'b1, 8'h00, 8'h3C);
      awaitGrant(gl);
      lReq = 1'b0;
      checkOutput("loc 3C", -1);

      $display("[TB] both requests held");
      order = '0;
      applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      for (int i = 0; i < 6; i++) begin
         awaitGrant(gl);
         order = {order[4:0], gl};
         sData = 8'($urandom);
         lData = 8'($urandom);
      end
      sReq = 1'b0;
      lReq = 1'b0;
      vectors++;
      if (order !== 6'b001001) reportFail("grant order", order, 6'b001001);
      checkOutput("both held", GAP + 1);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 1'b0, 8'($urandom), 8'h00);
      awaitGrant(gl);
      repeat (16) @(negedge clk);
      vectors++;
      if ({sel, busy} !== 2'b11) reportFail("frame active before reset", {sel, busy}, 2'b11);
      rst = 1'b1;
      #1;
      vectors++;
      if ({sAck, lAck, dOut, dClk, sel, busy} !== 6'b0)
         reportFail("outputs drop on reset", {sAck, lAck, dOut, dClk, sel, busy}, 0);
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
      obsQ.delete();
      modelStarve = 0;
      awaitGrant(gl);
      sReq = 1'b0;
      checkOutput("resend after reset", -1);

      $display("[TB] level-held state request");
      applyStimulus(1'b1, 1'b0, 8'($urandom), 8'h00);
      awaitGrant(gl);
      sData = 8'($urandom);
      awaitGrant(gl);
      sReq = 1'b0;
      checkOutput("level hold", GAP + 1);

      $display("[TB] request dropped before ack");
      applyStimulus(1'b1, 1'b0, 8'($urandom), 8'h00);
      awaitGrant(gl);
      sReq  = 1'b0;
      lData = 8'($urandom);
      lReq  = 1'b1;
      repeat (10) @(negedge clk);
      lReq = 1'b0;
      cnt  = 0;
      repeat (100) begin
         @(negedge clk);
         if (sAck || lAck) cnt++;
      end
      vectors++;
      if (cnt !== 0) reportFail("dropped req acks", cnt, 0);
      checkOutput("dropped req", -1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 16; i++) begin
         logic s, l;
         s = 1'($urandom_range(0, 1));
         l = 1'($urandom_range(0, 1));
         if (!s && !l) s = 1'b1;
         applyStimulus(s, l, 8'($urandom), 8'($urandom));
         awaitGrant(gl);
         if (gl) lReq = 1'b0;
         else    sReq = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            sReq = 1'b0;
            lReq = 1'b0;
            repeat ($urandom_range(1, 60)) @(negedge clk);
         end
      end
      sReq = 1'b0;
      lReq = 1'b0;
      checkOutput("random", -1);

      vectors++;
      if (highChgCnt !== 0) reportFail("data stable while clk high", highChgCnt, 0);
      vectors++;
      if (badAckCnt !== 0) reportFail("ack only at frame start", badAckCnt, 0);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog: aborts the run if the main sequence hangs.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, vectors %0d miscompares %0d", vectors, miscompares);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
